// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register, next-PC select and instruction fetch over a req/gnt/rvalid handshake.
// Latency: at least 2 cycles per instruction (REQ with gnt+rvalid together, then EXEC with instr_done).
// Backpressure: imem_req is held in REQ until imem_gnt; the instruction is held in EXEC until instr_done.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   PCSrc, imm, rs1        next-PC select and operands, sampled only when instr_done = 1
//   instr_done             retirement pulse for the instruction being presented
//   imem_req/addr          fetch request and address (address always equals pc)
//   imem_gnt/rvalid/rdata  memory grant, response valid and fetched word
//   instr, instr_valid     instruction presented to decode
//   pc, pc_plus4           current PC and its link value
//   misaligned, trap_pc    sticky misaligned-target flag and the offending target
//   instret                retired-instruction counter
module pc_fetch #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   PCSrc,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] rs1,
  input  logic         instr_done,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] instr,
  output logic         instr_valid,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         misaligned,
  output logic [N-1:0] trap_pc,
  output logic [N-1:0] instret
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  // Clear during reset and set on the first edge after release, so imem_req
  // stays low while rst_n is asserted even though the reset state is REQ.
  logic         r_run;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_instr;
  logic         r_misaligned;
  logic [N-1:0] r_trap_pc;
  logic [N-1:0] r_instret;

  logic         w_capture;
  logic         w_retire;
  logic         w_trap;
  logic [N-1:0] w_pc_plus4;
  logic [N-1:0] w_jalr_sum;
  logic [N-1:0] w_target;

  // Next-PC target; all sums wrap modulo 2^N. PCSrc 11 falls into pc+4.
  always_comb begin
    w_pc_plus4 = r_pc + N'(4);
    w_jalr_sum = rs1 + imm;
    case (PCSrc)
      2'b01:   w_target = r_pc + imm;
      2'b10:   w_target = {w_jalr_sum[N-1:1], 1'b0};
      default: w_target = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    w_trap      = 1'b0;
    case (r_state)
      S_REQ: begin
        // rvalid without gnt here belongs to an abandoned fetch and is dropped.
        if (r_run) begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            if (imem_rvalid) begin
              w_capture   = 1'b1;
              w_state_nxt = S_EXEC;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (instr_done) begin
          w_retire = 1'b1;
          // Only bit 1 is checked: bit 0 is cleared for JALR and tolerated otherwise.
          if (w_target[1]) begin
            w_trap      = 1'b1;
            w_state_nxt = S_TRAP;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_run        <= 1'b0;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_misaligned <= 1'b0;
      r_trap_pc    <= '0;
      r_instret    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_instret <= r_instret + N'(1);
        if (w_trap) begin
          r_misaligned <= 1'b1;
          r_trap_pc    <= w_target;
        end else begin
          r_pc <= w_target;
        end
      end
    end
  end

  assign imem_addr  = r_pc;
  assign instr      = r_instr;
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misaligned = r_misaligned;
  assign trap_pc    = r_trap_pc;
  assign instret    = r_instret;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with hand-computed expectations.
// Two instances share stimulus: one with RESET_PC = 0, one with RESET_PC = 0xFFFFFFFC.
// Inputs change 1 ns after the rising edge; outputs are checked at that point too.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] imm, rs1, imem_rdata;
  logic        instr_done, imem_gnt, imem_rvalid;

  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4, trap_pc, instret;

  logic        wr_imem_req, wr_instr_valid, wr_misaligned;
  logic [31:0] wr_imem_addr, wr_instr, wr_pc, wr_pc_plus4, wr_trap_pc, wr_instret;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(pc_src), .imm(imm), .rs1(rs1),
    .instr_done(instr_done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misaligned(misaligned), .trap_pc(trap_pc), .instret(instret)
  );

  pc_fetch #(.N(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .PCSrc(pc_src), .imm(imm), .rs1(rs1),
    .instr_done(instr_done), .imem_req(wr_imem_req), .imem_addr(wr_imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(wr_instr), .instr_valid(wr_instr_valid), .pc(wr_pc), .pc_plus4(wr_pc_plus4),
    .misaligned(wr_misaligned), .trap_pc(wr_trap_pc), .instret(wr_instret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " pc"}, pc, 32'h0);
    chk({tag, " pc_plus4"}, pc_plus4, 32'h4);
    chk({tag, " instr"}, instr, 32'h0);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, " imem_req"}, 32'(imem_req), 32'h0);
    chk({tag, " misaligned"}, 32'(misaligned), 32'h0);
    chk({tag, " trap_pc"}, trap_pc, 32'h0);
    chk({tag, " instret"}, instret, 32'h0);
    chk({tag, " wrap pc"}, wr_pc, 32'hFFFF_FFFC);
  endtask

  // Fetch one word at exp_addr: gnt held low for gnt_stall cycles, then rvalid
  // arrives rv_stall cycles after the grant (0 = same cycle as the grant).
  task automatic do_fetch(input logic [31:0] data, input int gnt_stall,
                          input int rv_stall, input logic [31:0] exp_addr);
    chk("fetch req", 32'(imem_req), 32'h1);
    chk("fetch addr", imem_addr, exp_addr);
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < gnt_stall; i++) begin
      imem_gnt = 1'b0;
      tick();
      chk("req held in gnt stall", 32'(imem_req), 32'h1);
    end
    imem_gnt = 1'b1;
    if (rv_stall == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      tick();
    end else begin
      tick();
      imem_gnt = 1'b0;
      chk("req low in WAIT", 32'(imem_req), 32'h0);
      for (int i = 1; i < rv_stall; i++) begin
        tick();
        chk("no valid in WAIT", 32'(instr_valid), 32'h0);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      tick();
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0BAD_F00D;
    chk("fetched instr", instr, data);
    chk("instr_valid after fetch", 32'(instr_valid), 32'h1);
  endtask

  task automatic retire(input logic [1:0] src, input logic [31:0] i_imm, input logic [31:0] i_rs1);
    pc_src     = src;
    imm        = i_imm;
    rs1        = i_rs1;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    pc_src     = 2'b00;
    imm        = 32'h5555_5555;
    rs1        = 32'h3333_3333;
  endtask

  initial begin
    rst_n = 1'b0; pc_src = 2'b00; imm = '0; rs1 = '0; instr_done = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk_reset_values("reset");
    chk("wrap pc_plus4 in reset", wr_pc_plus4, 32'h0);

    // Reset release and first fetch
    rst_n = 1'b1;
    tick();
    chk("req after release", 32'(imem_req), 32'h1);
    do_fetch(32'h0050_0093, 0, 1, 32'h0);
    chk("instret first", instret, 32'h0);
    // instr held while not retired; stray rvalid/gnt ignored in EXEC
    imem_rvalid = 1'b1; imem_gnt = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    chk("instr held", instr, 32'h0050_0093);
    chk("valid held", 32'(instr_valid), 32'h1);

    // Sequential with stalls
    retire(2'b00, 32'h40, 32'h0);
    chk("seq pc 4", pc, 32'h4);
    chk("req after retire", 32'(imem_req), 32'h1);
    chk("valid drops", 32'(instr_valid), 32'h0);
    chk("wrap pc 0", wr_pc, 32'h0);
    chk("wrap pc_plus4 4", wr_pc_plus4, 32'h4);
    do_fetch(32'h0000_0013, 3, 2, 32'h4);
    retire(2'b00, 32'h0, 32'h0);
    do_fetch(32'h0010_0113, 0, 0, 32'h8);
    retire(2'b00, 32'h0, 32'h0);
    chk("instret 3", instret, 32'h3);
    chk("seq pc C", pc, 32'hC);

    // Branch and JALR
    do_fetch(32'h0F40_0063, 0, 0, 32'hC);
    retire(2'b01, 32'h0000_00F4, 32'h0);
    chk("branch pc 100", pc, 32'h100);
    do_fetch(32'hFE00_0CE3, 0, 0, 32'h100);
    retire(2'b01, 32'hFFFF_FFF8, 32'h0);
    chk("back branch pc F8", pc, 32'hF8);
    chk("pc_plus4 FC", pc_plus4, 32'hFC);
    do_fetch(32'h0040_8067, 0, 0, 32'hF8);
    retire(2'b10, 32'h4, 32'h1001);
    chk("jalr pc 1004", pc, 32'h1004);
    do_fetch(32'h0000_0013, 1, 0, 32'h1004);
    retire(2'b11, 32'h0000_0700, 32'h0);
    chk("pcsrc11 pc 1008", pc, 32'h1008);
    do_fetch(32'h0000_8067, 0, 0, 32'h1008);
    retire(2'b10, 32'h0, 32'h100);
    chk("jalr pc 100", pc, 32'h100);
    chk("instret 8", instret, 32'h8);

    // Misaligned trap
    do_fetch(32'h0060_0063, 0, 0, 32'h100);
    retire(2'b01, 32'h6, 32'h0);
    chk("misaligned set", 32'(misaligned), 32'h1);
    chk("trap_pc", trap_pc, 32'h106);
    chk("pc unchanged", pc, 32'h100);
    chk("instret 9", instret, 32'h9);
    chk("no req in TRAP", 32'(imem_req), 32'h0);
    chk("no valid in TRAP", 32'(instr_valid), 32'h0);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; instr_done = 1'b1;
    tick(); tick(); tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_done = 1'b0;
    chk("TRAP ignores done", instret, 32'h9);
    chk("TRAP still no req", 32'(imem_req), 32'h0);
    chk("TRAP sticky", 32'(misaligned), 32'h1);
    chk("TRAP pc", pc, 32'h100);

    // Reset in TRAP: immediate
    rst_n = 1'b0;
    #1;
    chk_reset_values("reset in TRAP");
    tick();
    rst_n = 1'b1;
    tick();
    // Reset in WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("in WAIT req low", 32'(imem_req), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_values("reset in WAIT");
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
    tick(); tick();
    imem_rvalid = 1'b0;
    chk("stale rvalid valid", 32'(instr_valid), 32'h0);
    chk("stale rvalid instr", instr, 32'h0);
    chk("req after stale", 32'(imem_req), 32'h1);

    // PCSrc 11 on the wrap instance behaves as pc+4
    do_fetch(32'h0000_0013, 0, 0, 32'h0);
    retire(2'b11, 32'h0000_0040, 32'h0);
    chk("wrap pcsrc11 pc", wr_pc, 32'h0);
    chk("wrap pcsrc11 pc_plus4", wr_pc_plus4, 32'h4);
    chk("pcsrc11 main pc", pc, 32'h4);
    chk("wrap instret", wr_instret, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
